// File: rtl/alu_pkg.sv
// Shared ALU definitions: MIPS funct codes and the multiplier FSM state encoding.
package alu_pkg;

  localparam logic [5:0] ADD   = 6'b100000;
  localparam logic [5:0] SUB   = 6'b100010;
  localparam logic [5:0] AND   = 6'b100100;
  localparam logic [5:0] OR    = 6'b100101;
  localparam logic [5:0] SLT   = 6'b101010;
  localparam logic [5:0] SRL   = 6'b000010;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MFLO  = 6'b010010;
  localparam logic [5:0] MULTU = 6'b011001;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/multu_hilo_unit_if.sv
// Execution-stage result bus: operands, function code, upstream results and the selected output.
interface multu_hilo_unit_if;

  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [5:0]  Signal;
  logic [31:0] aluOut;
  logic [31:0] shifterOut;
  logic [31:0] dataOut;
  logic        busy;
  logic        done;

  modport master (
    output dataA, dataB, Signal, aluOut, shifterOut,
    input  dataOut, busy, done
  );

  modport slave (
    input  dataA, dataB, Signal, aluOut, shifterOut,
    output dataOut, busy, done
  );

endinterface

// File: rtl/multu_hilo_unit_core.sv
// 32-step shift-add unsigned multiplier; load_o strobes the final stepped product for HI/LO.
module multu_core
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [31:0] mcand_i,
  input  logic [31:0] mplier_i,
  output logic [63:0] product_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        load_o
);

  state_e      state_q, state_d;
  logic [63:0] prod_q, prod_d;
  logic [31:0] mcand_q, mcand_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic [32:0] upper;
  logic [63:0] step;

  // 33-bit add keeps the carry so all-ones operands do not overflow the top half
  always_comb begin
    upper = prod_q[0] ? ({1'b0, prod_q[63:32]} + {1'b0, mcand_q})
                      : {1'b0, prod_q[63:32]};
    step  = {upper, prod_q[31:1]};
  end

  always_comb begin
    state_d = state_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    load_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          prod_d  = {32'b0, mplier_i};
          mcand_d = mcand_i;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        prod_d = step;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          done_d  = 1'b1;
          load_o  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      prod_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign product_o = step;
  assign busy_o    = (state_q == RUN);
  assign done_o    = done_q;

endmodule

// File: rtl/multu_hilo_unit.sv
// HI/LO register pair plus the execution-stage result selector around the MULTU core.
module multu_hilo_unit
  import alu_pkg::*;
(
  input logic               clk,
  input logic               reset,
  multu_hilo_unit_if.slave  bus
);

  logic [31:0] hi_q, lo_q;
  logic [63:0] product;
  logic        load;

  multu_core u_core (
    .clk       (clk),
    .reset     (reset),
    .start_i   (bus.Signal == MULTU),
    .mcand_i   (bus.dataA),
    .mplier_i  (bus.dataB),
    .product_o (product),
    .busy_o    (bus.busy),
    .done_o    (bus.done),
    .load_o    (load)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (load) begin
      hi_q <= product[63:32];
      lo_q <= product[31:0];
    end
  end

  always_comb begin
    bus.dataOut = '0;
    if (!reset) begin
      case (bus.Signal)
        ADD, SUB, AND, OR, SLT: bus.dataOut = bus.aluOut;
        SRL:                    bus.dataOut = bus.shifterOut;
        MFHI:                   bus.dataOut = hi_q;
        MFLO:                   bus.dataOut = lo_q;
        default:                bus.dataOut = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_multu_hilo_unit.sv
// Directed bench for multu_hilo_unit with a product scoreboard checked against HI/LO.
module tb_multu_hilo_unit;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multu_hilo_unit_if bus ();

  multu_hilo_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [63:0] exp_q[$];

  always @(negedge clk) if (bus.done) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic read_hilo(input string tag, input logic [63:0] exp);
    bus.Signal = MFHI; #1;
    check({tag, "_hi"}, bus.dataOut, exp[63:32]);
    bus.Signal = MFLO; #1;
    check({tag, "_lo"}, bus.dataOut, exp[31:0]);
    bus.Signal = 6'b111111;
  endtask

  // Launch, count busy cycles until done, then pop the scoreboard and compare HI/LO
  task automatic multiply(input string tag, input logic [31:0] a, input logic [31:0] b);
    int busy_cycles;
    int waited;
    int d0;
    logic [63:0] exp;
    bus.dataA  = a;
    bus.dataB  = b;
    bus.Signal = MULTU;
    exp_q.push_back({32'b0, a} * {32'b0, b});
    #1;
    check({tag, "_multu_out"}, bus.dataOut, 32'h0);
    d0 = done_cnt;
    tick();
    bus.Signal = 6'b111111;
    bus.dataA  = $urandom;
    bus.dataB  = $urandom;
    busy_cycles = 0;
    waited = 0;
    while (!bus.done && waited < 40) begin
      if (bus.busy) busy_cycles++;
      tick();
      waited++;
    end
    check({tag, "_busy_cycles"}, busy_cycles, 32);
    check({tag, "_done"}, {31'b0, bus.done}, 32'h1);
    tick();
    check({tag, "_done_once"}, done_cnt - d0, 1);
    check({tag, "_busy_after"}, {31'b0, bus.busy}, 32'h0);
    exp = exp_q.pop_front();
    read_hilo(tag, exp);
  endtask

  initial begin
    int d0;
    logic [31:0] ra, rb;
    bus.dataA = '0; bus.dataB = '0; bus.aluOut = '0;
    bus.Signal = SRL; bus.shifterOut = 32'h1234;
    tick(); tick();
    check("reset_dataout", bus.dataOut, 32'h0);
    check("reset_busy", {31'b0, bus.busy}, 32'h0);
    check("reset_done", {31'b0, bus.done}, 32'h0);
    reset = 1'b0;
    bus.Signal = 6'b111111;
    tick();
    read_hilo("idle", 64'h0);

    multiply("m3x5", 32'd3, 32'd5);
    multiply("mffff", 32'hFFFFFFFF, 32'hFFFFFFFF);
    ra = $urandom; rb = $urandom;
    multiply("mrand", ra, rb);

    // Second MULTU mid-run must be ignored
    d0 = done_cnt;
    bus.dataA = 32'h10000; bus.dataB = 32'h10000; bus.Signal = MULTU;
    tick();
    bus.Signal = 6'b111111;
    repeat (4) tick();
    bus.dataA = 32'd7; bus.dataB = 32'd7; bus.Signal = MULTU;
    tick();
    bus.Signal = 6'b111111;
    repeat (40) tick();
    check("ignore_done_count", done_cnt - d0, 1);
    read_hilo("ignore", 64'h1_0000_0000);

    // Reset during the run aborts without a done pulse and clears HI/LO
    d0 = done_cnt;
    bus.dataA = 32'd3; bus.dataB = 32'd5; bus.Signal = MULTU;
    tick();
    bus.Signal = 6'b111111;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", {31'b0, bus.busy}, 32'h0);
    repeat (40) tick();
    check("abort_no_done", done_cnt - d0, 0);
    read_hilo("abort", 64'h0);

    // Reset and MULTU on the same edge: reset wins
    reset = 1'b1; bus.Signal = MULTU;
    tick();
    reset = 1'b0; bus.Signal = 6'b111111;
    check("reset_wins_busy", {31'b0, bus.busy}, 32'h0);

    bus.Signal = SRL; bus.shifterOut = 32'h0000_00F0; #1;
    check("pass_srl", bus.dataOut, 32'h0000_00F0);
    bus.Signal = ADD; bus.aluOut = 32'hCAFE; #1;
    check("pass_add", bus.dataOut, 32'hCAFE);
    bus.Signal = SLT; bus.aluOut = 32'h1; #1;
    check("pass_slt", bus.dataOut, 32'h1);
    bus.Signal = 6'b111111; #1;
    check("pass_other", bus.dataOut, 32'h0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multu_hilo_unit.md
# multu_hilo_unit

Sequential 32x32 unsigned multiplier with its HI/LO register pair and the final ALU result selector. It sits directly downstream of the shifter and the ALU. It consumes their combinational results, runs MULTU as a 32-step shift-add operation, and drives the single 32-bit execution-stage result selected by the 6-bit function code.

## Interface
- No parameters; widths fixed at 32-bit operands and 64-bit product.
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- dataA  in  32  multiplicand; sampled only at MULTU launch
- dataB  in  32  multiplier; sampled only at MULTU launch
- Signal  in  6  function code (MIPS funct encoding)
- aluOut  in  32  ALU result, passed through for ALU codes
- shifterOut  in  32  shifter result, passed through for SRL
- dataOut  out  32  selected result, combinational
- busy  out  1  high while a multiply is in progress
- done  out  1  one-cycle pulse when HI/LO receive a new product

## Operation
- Function codes:
  - ADD 100000, SUB 100010, AND 100100, OR 100101 and SLT 101010 select aluOut.
  - SRL 000010 selects shifterOut.
  - MFHI 010000 selects hi and MFLO 010010 selects lo.
  - MULTU 011001 launches a multiply.
  - Any other code selects 32'b0.
  - MULTU itself outputs 0.
- FSM states are IDLE and RUN.
- IDLE, Signal==MULTU at a clock edge:
  - prod <= {32'b0, dataB}, mcand <= dataA, cnt <= 0.
  - state <= RUN, busy <= 1.
- RUN, each edge:
  - upper = prod[0] ? ({1'b0,prod[63:32]} + {1'b0,mcand}) : {1'b0,prod[63:32]}.
  - This add is 33-bit with the carry kept.
  - prod <= {upper, prod[31:1]}, cnt <= cnt+1.
- RUN, edge with cnt==31:
  - The step is performed.
  - {hi,lo} <= the stepped product, done <= 1.
  - state <= IDLE, busy <= 0.
- done is cleared on every other edge.
- MULTU presented while in RUN is ignored: no restart and no queuing. Operand changes during RUN have no effect.
- MULTU held continuously in IDLE relaunches on each IDLE edge. The controlling logic presents MULTU for exactly one cycle.
- MFHI/MFLO during RUN return the previous HI/LO. Stalling on busy is the controller's job.
- dataOut is forced to 0 while reset is high, independent of Signal.

## Timing
- Reset edge: hi=0, lo=0, prod=0, mcand=0, cnt=0, state=IDLE, busy=0, done=0.
- Reset mid-RUN aborts the operation. HI/LO clear to 0 and no done pulse is produced.
- Launch edge E0; step edges E1..E32.
- busy is high from after E0 through E32. New HI/LO and done=1 are visible in the cycle after E32.
- Latency is 32 cycles from launch to result. The next MULTU may launch at E33, coincident with the done cycle.
- Simultaneous reset and MULTU: reset wins.
- dataOut has zero latency: a pure mux of current inputs and registered hi/lo.

## Structure
- Shared package alu_pkg holds:
  - the funct localparams ADD, SUB, AND, OR, SLT, SRL, MULTU, MFHI, MFLO;
  - the FSM state encoding, IDLE=1'b0 and RUN=1'b1.
- The shifter imports the same SRL constant from alu_pkg.
- One sub-module, multu_core, contains the FSM, the prod/mcand/cnt registers and the shift-add step. It outputs product[63:0], busy and done.
- The top level holds the hi/lo registers and the result mux.

## Test plan
- Reset then idle: after reset, busy=0, done=0, and MFHI and MFLO both read 32'h00000000. With reset held, dataOut=0 for Signal=SRL and shifterOut=32'h1234.
- dataA=3, dataB=5, MULTU for one cycle: busy is high for 32 cycles, then done pulses once. Afterwards MFLO=32'h0000000F and MFHI=32'h00000000.
- dataA=dataB=32'hFFFFFFFF (carry-out path): MFHI=32'hFFFFFFFE and MFLO=32'h00000001.
- Launch 32'h10000 x 32'h10000, then present MULTU again with 7x7 at cycle 5: the second request is ignored. Final MFHI=32'h00000001, MFLO=0, and exactly one done pulse.
- Launch 3x5, assert reset at step 10: busy=0 next cycle, no done pulse, and HI=LO=0.
- Passthrough checks:
  - Signal=SRL with shifterOut=32'h0000_00F0 gives dataOut=32'h0000_00F0.
  - Signal=ADD with aluOut=32'hCAFE gives dataOut=32'hCAFE.
  - Signal=6'b111111 gives dataOut=0.
